hier_fanout_node: RTL and testbench



---
 rtl/hier_node_pkg.sv | 18 +
 rtl/hier_leaf_counter.sv | 37 +++
 rtl/hier_fanout_node.sv | 118 +++++++++++
 tb/tb_hier_fanout_node.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/hier_node_pkg.sv
// Shared types and sizing helpers for the hierarchy fan-out node and its leaves.
package hier_node_pkg;

    localparam int MAX_CHILD = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_DONE
    } node_state_t;

    // Elapsed-cycle width: worst case is NUM_CHILD + 2^CNT_W, plus headroom.
    function automatic int calc_cyc_w(input int cnt_w, input int n_child);
        return cnt_w + $clog2(n_child) + 2;
    endfunction

endpackage

// File: rtl/hier_leaf_counter.sv
// Leaf down-counter: loaded with a length, raises a sticky done as it counts out.
module hier_leaf_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] len,
    input  logic             clear,
    output logic             done
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else if (clear) begin
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else if (load) begin
            r_cnt  <= len;
            r_done <= 1'b0;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1))
                r_done <= 1'b1;
        end
    end

    // Done is already visible in the final count cycle, so a child loaded in
    // cycle c reports done from cycle c+len onward.
    assign done = r_done | (r_cnt == CNT_W'(1));

endmodule

// File: rtl/hier_fanout_node.sv
// Hierarchy node: launches NUM_CHILD leaf counters one per cycle, reports elapsed cycles.
// Optional feature macro: HIER_NODE_DONE_MASK_EN exposes the per-child done flags.
module hier_fanout_node
    import hier_node_pkg::*;
#(
    parameter  int NUM_CHILD = 5,
    parameter  int CNT_W     = 8,
    localparam int CYC_W     = calc_cyc_w(CNT_W, NUM_CHILD)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_valid,
    output logic                 start_ready,
    input  logic [CNT_W-1:0]     start_len,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done_valid,
    input  logic                 done_ready,
`ifdef HIER_NODE_DONE_MASK_EN
    output logic [CYC_W-1:0]     done_cycles,
    output logic [NUM_CHILD-1:0] done_mask
`else
    output logic [CYC_W-1:0]     done_cycles
`endif
);

    if (NUM_CHILD < 1 || NUM_CHILD > MAX_CHILD) begin : g_bad_cfg
        $error("hier_fanout_node: NUM_CHILD out of range");
    end

    node_state_t            r_state, w_next;
    logic [CNT_W-1:0]       r_len;
    logic [CYC_W-1:0]       r_cyc;
    logic [NUM_CHILD-1:0]   r_ptr;
    logic [NUM_CHILD-1:0]   w_load;
    logic [NUM_CHILD-1:0]   w_done;
    logic                   w_accept, w_abort, w_clear, w_all_done;

    assign start_ready = (r_state == ST_IDLE);
    assign busy        = (r_state == ST_LAUNCH) || (r_state == ST_WAIT);
    assign done_valid  = (r_state == ST_DONE);
    assign done_cycles = r_cyc;

    assign w_accept   = start_ready && start_valid;
    assign w_abort    = busy && abort;
    assign w_clear    = w_accept || w_abort;
    assign w_all_done = &w_done;
    assign w_load     = ((r_state == ST_LAUNCH) && !abort) ? r_ptr : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (start_valid) w_next = ST_LAUNCH;
            ST_LAUNCH: begin
                if (abort)                   w_next = ST_IDLE;
                else if (r_ptr[NUM_CHILD-1]) w_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (abort)           w_next = ST_IDLE;
                else if (w_all_done) w_next = ST_DONE;
            end
            ST_DONE:   if (done_ready) w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Counter starts at 1 so the accept cycle itself is included in the total.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len <= '0;
            r_cyc <= '0;
            r_ptr <= '0;
        end else if (w_accept) begin
            r_len <= (start_len == '0) ? CNT_W'(1) : start_len;
            r_cyc <= CYC_W'(1);
            r_ptr <= NUM_CHILD'(1);
        end else begin
            if (r_state == ST_LAUNCH)
                r_ptr <= r_ptr << 1;
            if (busy && (r_cyc != '1))
                r_cyc <= r_cyc + CYC_W'(1);
        end
    end

`ifdef HIER_NODE_DONE_MASK_EN
    logic [NUM_CHILD-1:0] r_mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_mask <= '0;
        else
            r_mask <= w_clear ? '0 : w_done;
    end

    assign done_mask = r_mask;
`endif

    for (genvar g = 0; g < NUM_CHILD; g++) begin : inst
        hier_leaf_counter #(
            .CNT_W (CNT_W)
        ) u_leaf (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (w_load[g]),
            .len   (r_len),
            .clear (w_clear),
            .done  (w_done[g])
        );
    end

endmodule

// File: tb/tb_hier_fanout_node.sv
// Bench for hier_fanout_node: vector table, random jobs vs. latency model, corner sequences.
module tb_hier_fanout_node;

    localparam int N  = 5;
    localparam int CW = 8;
    localparam int YW = CW + $clog2(N) + 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          start_valid = 1'b0, abort = 1'b0, done_ready = 1'b0;
    logic [CW-1:0] start_len = '0;
    logic          start_ready, busy, done_valid;
    logic [YW-1:0] done_cycles;

    logic       s1_sv = 1'b0, s1_ab = 1'b0, s1_dr = 1'b0;
    logic [3:0] s1_len = '0;
    logic       s1_sr, s1_busy, s1_dv;
    logic [5:0] s1_dc;

`ifdef HIER_NODE_DONE_MASK_EN
    logic [N-1:0] done_mask;
    logic [0:0]   s1_mask;
`endif

    hier_fanout_node #(.NUM_CHILD(N), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .start_valid(start_valid), .start_ready(start_ready), .start_len(start_len),
        .abort(abort), .busy(busy),
        .done_valid(done_valid), .done_ready(done_ready),
`ifdef HIER_NODE_DONE_MASK_EN
        .done_cycles(done_cycles), .done_mask(done_mask)
`else
        .done_cycles(done_cycles)
`endif
    );

    hier_fanout_node #(.NUM_CHILD(1), .CNT_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .start_valid(s1_sv), .start_ready(s1_sr), .start_len(s1_len),
        .abort(s1_ab), .busy(s1_busy),
        .done_valid(s1_dv), .done_ready(s1_dr),
`ifdef HIER_NODE_DONE_MASK_EN
        .done_cycles(s1_dc), .done_mask(s1_mask)
`else
        .done_cycles(s1_dc)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: a job of length s finishes N+max(s,1)+1 cycles after accept;
    // the node is busy for every cycle in between.
    task automatic run_job(input string nm, input int len, input int hold,
                           input bit ab, input int ab_at, input int exp, input bit stray);
        int n, be, se, dv_cnt;
        chk({nm, ".ready"}, start_ready, 1);
        start_valid = 1'b1;
        start_len   = CW'(len);
        tick();
        start_valid = 1'b0;
        n = 1;
        if (ab) begin
            while (n < ab_at) begin tick(); n++; end
            abort = 1'b1;
            tick();
            abort = 1'b0;
            chk({nm, ".ab_busy"}, busy, 0);
            chk({nm, ".ab_ready"}, start_ready, 1);
            dv_cnt = 0;
            for (int i = 0; i < 20; i++) begin
                if (done_valid) dv_cnt++;
                tick();
            end
            chk({nm, ".ab_no_done"}, dv_cnt, 0);
`ifdef HIER_NODE_DONE_MASK_EN
            chk({nm, ".ab_mask"}, done_mask, 0);
`endif
            return;
        end
        be = 0;
        while (n <= exp + 20) begin
            if (busy !== (n < exp)) be++;
            if (done_valid) break;
            start_valid = stray && (n == 2);
            start_len   = 8'd99;
            tick();
            n++;
        end
        start_valid = 1'b0;
        chk({nm, ".latency"}, n, exp);
        chk({nm, ".cycles"}, done_cycles, exp);
        chk({nm, ".busy_win"}, be, 0);
`ifdef HIER_NODE_DONE_MASK_EN
        chk({nm, ".mask"}, done_mask, 5'h1f);
`endif
        se = 0;
        for (int i = 0; i < hold; i++) begin
            abort = (i == 0);
            tick();
            if (!done_valid || done_cycles !== YW'(exp) || start_ready) se++;
        end
        abort = 1'b0;
        if (hold > 0) chk({nm, ".hold"}, se, 0);
        done_ready = 1'b1;
        tick();
        done_ready = 1'b0;
        chk({nm, ".post_ready"}, start_ready, 1);
        chk({nm, ".post_dv"}, done_valid, 0);
    endtask

    typedef struct {
        int len;
        int hold;
        bit ab;
        int ab_at;
        int exp;
        bit stray;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int L, n;
        vecs[0] = '{3,   0,  1'b0, 0, 9,   1'b0};
        vecs[1] = '{0,   10, 1'b0, 0, 7,   1'b0};
        vecs[2] = '{1,   2,  1'b0, 0, 7,   1'b1};
        vecs[3] = '{255, 0,  1'b0, 0, 261, 1'b0};
        vecs[4] = '{10,  0,  1'b1, 4, 0,   1'b0};
        vecs[5] = '{7,   1,  1'b0, 0, 13,  1'b1};
        vecs[6] = '{2,   0,  1'b1, 1, 0,   1'b0};
        vecs[7] = '{4,   0,  1'b1, 9, 0,   1'b0};

        #3;
        chk("rst.ready", start_ready, 1);
        chk("rst.busy", busy, 0);
        chk("rst.dv", done_valid, 0);
        chk("rst.cycles", done_cycles, 0);
`ifdef HIER_NODE_DONE_MASK_EN
        chk("rst.mask", done_mask, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("idle_abort.ready", start_ready, 1);
        chk("idle_abort.busy", busy, 0);

        for (int v = 0; v < 8; v++)
            run_job($sformatf("vec%0d", v), vecs[v].len, vecs[v].hold, vecs[v].ab,
                    vecs[v].ab_at, vecs[v].exp, vecs[v].stray);

        for (int r = 0; r < 25; r++) begin
            int len, hold, ab_at;
            bit ab;
            len   = int'($urandom_range(0, 255));
            hold  = int'($urandom_range(0, 3));
            ab    = ($urandom_range(0, 3) == 0);
            L     = (len == 0) ? 1 : len;
            ab_at = int'($urandom_range(1, N + L));
            run_job($sformatf("rnd%0d", r), len, hold, ab, ab_at, N + L + 1, 1'b0);
        end

        // Reset asserted while the node is waiting on its children.
        start_valid = 1'b1;
        start_len   = 8'd20;
        tick();
        start_valid = 1'b0;
        repeat (10) tick();
        chk("midrst.busy_before", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst.ready", start_ready, 1);
        chk("midrst.busy", busy, 0);
        chk("midrst.dv", done_valid, 0);
        chk("midrst.cycles", done_cycles, 0);
`ifdef HIER_NODE_DONE_MASK_EN
        chk("midrst.mask", done_mask, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_job("after_rst", 3, 0, 1'b0, 0, 9, 1'b0);

        // Single-child node with a full-scale 4-bit length.
        s1_sv  = 1'b1;
        s1_len = 4'd15;
        tick();
        s1_sv = 1'b0;
        n = 1;
        while (!s1_dv && n < 60) begin tick(); n++; end
        chk("n1.latency", n, 17);
        chk("n1.cycles", s1_dc, 17);
        chk("n1.busy", s1_busy, 0);
`ifdef HIER_NODE_DONE_MASK_EN
        chk("n1.mask", s1_mask, 1);
`endif
        s1_dr = 1'b1;
        tick();
        s1_dr = 1'b0;
        chk("n1.post_ready", s1_sr, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
